// File: rtl/cluster_tx_scheduler.sv
// Per-BX cluster scheduler: compacts valid clusters into a multi-write circular
// buffer and drains one cluster per clock4x cycle onto the trigger link.
module cluster_tx_scheduler #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned CNT_W = 16
) (
  input  logic                     clock4x,
  input  logic                     global_reset,
  input  logic                     cluster_valid,
  input  logic [13:0]              cluster0,
  input  logic [13:0]              cluster1,
  input  logic [13:0]              cluster2,
  input  logic [13:0]              cluster3,
  input  logic [13:0]              cluster4,
  input  logic [13:0]              cluster5,
  input  logic [13:0]              cluster6,
  input  logic [13:0]              cluster7,
  input  logic                     resync,
  output logic [13:0]              tx_data,
  output logic                     tx_valid,
  output logic                     tx_frame_start,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic [CNT_W-1:0]         drop_cnt,
  output logic                     overflow
);

  localparam int unsigned AW  = $clog2(DEPTH);
  localparam int unsigned OW  = AW + 1;
  localparam int unsigned NCL = 8;
  localparam int unsigned CW  = 14;
  localparam int unsigned SW  = CNT_W + 1;
  localparam logic [CW-1:0] IDLE_WORD = 14'h07FF;
  localparam logic [10:0]   ADR_LIMIT = 11'd1536;

  logic [CW-1:0]    mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [OW-1:0]    occ_q, occ_d;
  logic [1:0]       phase_q, phase_d;
  logic [CW-1:0]    tx_data_q, tx_data_d;
  logic             tx_valid_q, tx_valid_d;
  logic             tx_fs_q, tx_fs_d;
  logic [CNT_W-1:0] drop_q, drop_d;
  logic             ovf_q, ovf_d;

  logic [CW-1:0]    cl     [NCL];
  logic [OW-1:0]    rank   [NCL];
  logic [AW-1:0]    waddr  [NCL];
  logic [NCL-1:0]   valid;
  logic [NCL-1:0]   wr_en;
  logic [OW-1:0]    n_valid;
  logic [OW-1:0]    free_slots;
  logic [OW-1:0]    n_wr;
  logic [OW-1:0]    n_drop;
  logic [SW-1:0]    drop_sum;
  logic             accept;
  logic             pop;

  always_comb begin
    cl[0] = cluster0;
    cl[1] = cluster1;
    cl[2] = cluster2;
    cl[3] = cluster3;
    cl[4] = cluster4;
    cl[5] = cluster5;
    cl[6] = cluster6;
    cl[7] = cluster7;
  end

  // Idle (0x7FF) and any address beyond the last strip are not real clusters
  always_comb begin
    valid = '0;
    for (int i = 0; i < NCL; i++) begin
      valid[i] = (cl[i][10:0] < ADR_LIMIT);
    end
  end

  // Rank = position of a valid cluster among the valid ones, in index order
  always_comb begin
    n_valid = '0;
    for (int i = 0; i < NCL; i++) begin
      rank[i] = n_valid;
      if (valid[i]) begin
        n_valid = n_valid + OW'(1);
      end
    end
  end

  always_comb begin
    accept     = cluster_valid && !resync;
    pop        = (occ_q != '0) && !resync;
    free_slots = OW'(DEPTH) - occ_q;
    n_wr       = '0;
    n_drop     = '0;
    if (accept) begin
      n_wr   = (n_valid < free_slots) ? n_valid : free_slots;
      n_drop = n_valid - n_wr;
    end
    for (int i = 0; i < NCL; i++) begin
      wr_en[i] = accept && valid[i] && (rank[i] < free_slots);
      waddr[i] = wptr_q + AW'(rank[i]);
    end
  end

  always_comb begin
    wptr_d     = wptr_q + AW'(n_wr);
    rptr_d     = rptr_q + AW'(pop);
    occ_d      = occ_q + n_wr - OW'(pop);
    phase_d    = phase_q + 2'd1;
    tx_data_d  = pop ? mem_q[rptr_q] : IDLE_WORD;
    tx_valid_d = pop;
    tx_fs_d    = !resync && (phase_q == 2'd0);
    drop_sum   = SW'(drop_q) + SW'(n_drop);
    drop_d     = drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
    ovf_d      = ovf_q || (n_drop != '0);
    if (resync) begin
      wptr_d  = '0;
      rptr_d  = '0;
      occ_d   = '0;
      phase_d = '0;
    end
  end

  always_ff @(posedge clock4x) begin
    if (global_reset) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      occ_q      <= '0;
      phase_q    <= '0;
      tx_data_q  <= IDLE_WORD;
      tx_valid_q <= 1'b0;
      tx_fs_q    <= 1'b0;
      drop_q     <= '0;
      ovf_q      <= 1'b0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      occ_q      <= occ_d;
      phase_q    <= phase_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      tx_fs_q    <= tx_fs_d;
      drop_q     <= drop_d;
      ovf_q      <= ovf_d;
    end
  end

  // Storage needs no reset: occupancy alone decides what is ever read out
  always_ff @(posedge clock4x) begin
    for (int i = 0; i < NCL; i++) begin
      if (!global_reset && wr_en[i]) begin
        mem_q[waddr[i]] <= cl[i];
      end
    end
  end

  assign tx_data        = tx_data_q;
  assign tx_valid       = tx_valid_q;
  assign tx_frame_start = tx_fs_q;
  assign occupancy      = occ_q;
  assign drop_cnt       = drop_q;
  assign overflow       = ovf_q;

endmodule

// File: tb/tb_cluster_tx_scheduler.sv
// Directed bench for cluster_tx_scheduler with hand-computed expectations.
module tb_cluster_tx_scheduler;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned CNT_W = 16;
  localparam logic [13:0] IDLE  = 14'h07FF;

  logic        clock4x = 1'b0;
  logic        global_reset;
  logic        cluster_valid;
  logic        resync;
  logic [13:0] cl [8];
  logic [13:0] tx_data;
  logic        tx_valid;
  logic        tx_frame_start;
  logic [4:0]  occupancy;
  logic [15:0] drop_cnt;
  logic        overflow;

  int checks = 0;
  int errors = 0;

  always #5 clock4x = ~clock4x;

  cluster_tx_scheduler #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clock4x        (clock4x),
    .global_reset   (global_reset),
    .cluster_valid  (cluster_valid),
    .cluster0       (cl[0]),
    .cluster1       (cl[1]),
    .cluster2       (cl[2]),
    .cluster3       (cl[3]),
    .cluster4       (cl[4]),
    .cluster5       (cl[5]),
    .cluster6       (cl[6]),
    .cluster7       (cl[7]),
    .resync         (resync),
    .tx_data        (tx_data),
    .tx_valid       (tx_valid),
    .tx_frame_start (tx_frame_start),
    .occupancy      (occupancy),
    .drop_cnt       (drop_cnt),
    .overflow       (overflow)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock4x);
    #1;
  endtask

  task automatic set_cl(input int n, input logic [13:0] base);
    for (int i = 0; i < 8; i++) cl[i] = (i < n) ? base + 14'(i) : IDLE;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [13:0] t1_data [4];
    logic        t1_fs   [4];
    logic [4:0]  t2_occ  [5];
    logic [15:0] t2_drop [5];
    logic [13:0] exp_q [$];
    int occ_m, drop_m, f, need, n, w, iter;

    t1_data = '{14'h0000, 14'h0000, 14'h0001, IDLE};
    t1_data[0] = IDLE;
    t1_fs   = '{1'b1, 1'b0, 1'b0, 1'b0};
    t2_occ  = '{5'd8, 5'd12, 5'd15, 5'd15, 5'd15};
    t2_drop = '{16'd0, 16'd0, 16'd1, 16'd5, 16'd9};

    // Reset state
    global_reset = 1'b1; cluster_valid = 1'b0; resync = 1'b0;
    set_cl(0, 14'h0);
    tick();
    chk("rst_tx_data", 32'(tx_data), 32'h7FF);
    chk("rst_tx_valid", 32'(tx_valid), 0);
    chk("rst_fs", 32'(tx_frame_start), 0);
    chk("rst_occ", 32'(occupancy), 0);
    chk("rst_drop", 32'(drop_cnt), 0);
    chk("rst_ovf", 32'(overflow), 0);
    global_reset = 1'b0;

    // Two valid clusters per BX, strobe every 4th edge
    set_cl(2, 14'h0000);
    for (int e = 0; e < 8; e++) begin
      cluster_valid = (e % 4 == 0);
      tick();
      chk("t1_data", 32'(tx_data), 32'(t1_data[e % 4]));
      chk("t1_valid", 32'(tx_valid), (e % 4 == 1 || e % 4 == 2) ? 1 : 0);
      chk("t1_fs", 32'(tx_frame_start), 32'(t1_fs[e % 4]));
      if (e % 4 == 0) chk("t1_occ", 32'(occupancy), 2);
    end
    chk("t1_drop", 32'(drop_cnt), 0);

    // Eight valid clusters per BX: buffer fills, then overflows
    set_cl(8, 14'h0800);
    for (int t = 0; t < 20; t++) begin
      cluster_valid = (t % 4 == 0);
      tick();
      if (t % 4 == 0) begin
        chk("t2_occ", 32'(occupancy), 32'(t2_occ[t / 4]));
        chk("t2_drop", 32'(drop_cnt), 32'(t2_drop[t / 4]));
        chk("t2_ovf", 32'(overflow), (t >= 8) ? 1 : 0);
      end
      if (t >= 1) chk("t2_valid", 32'(tx_valid), 1);
      if (t >= 1 && t <= 8) chk("t2_data", 32'(tx_data), 32'h800 + 32'(t - 1));
    end
    cluster_valid = 1'b0;

    // Reset mid-drain with six entries pending
    for (int t = 0; t < 6; t++) tick();
    chk("t6_occ_pre", 32'(occupancy), 6);
    global_reset = 1'b1;
    tick();
    chk("t6_tx_data", 32'(tx_data), 32'h7FF);
    chk("t6_tx_valid", 32'(tx_valid), 0);
    chk("t6_fs", 32'(tx_frame_start), 0);
    chk("t6_occ", 32'(occupancy), 0);
    chk("t6_drop", 32'(drop_cnt), 0);
    chk("t6_ovf", 32'(overflow), 0);
    global_reset = 1'b0;
    for (int t = 0; t < 4; t++) begin
      tick();
      chk("t6_no_stale", 32'(tx_valid), 0);
      chk("t6_idle_occ", 32'(occupancy), 0);
    end

    // Wrap-around write at wptr=14 with partial drop, plus adr 1535/1536 boundary
    for (int i = 0; i < 8; i++) exp_q.push_back(14'h1000 + 14'(i));
    exp_q.push_back(14'h1810); exp_q.push_back(14'h1812); exp_q.push_back(14'h1814);
    exp_q.push_back(14'h1815); exp_q.push_back(14'h1816); exp_q.push_back(14'h1DFF);
    for (int i = 0; i < 5; i++) exp_q.push_back(14'h3900 + 14'(i));
    for (int e = 1; e <= 21; e++) begin
      cluster_valid = (e == 1 || e == 2 || e == 5);
      if (e == 1) set_cl(8, 14'h1000);
      if (e == 2) begin
        cl[0] = 14'h1810; cl[1] = 14'h1600; cl[2] = 14'h1812; cl[3] = IDLE;
        cl[4] = 14'h1814; cl[5] = 14'h1815; cl[6] = 14'h1816; cl[7] = 14'h1DFF;
      end
      if (e == 5) set_cl(8, 14'h3900);
      tick();
      if (e >= 2 && e <= 20) begin
        chk("t3_data", 32'(tx_data), 32'(exp_q[e - 2]));
        chk("t3_valid", 32'(tx_valid), 1);
      end else begin
        chk("t3_idle_data", 32'(tx_data), 32'h7FF);
        chk("t3_idle_valid", 32'(tx_valid), 0);
      end
      if (e == 4) begin
        chk("t3_occ_pre", 32'(occupancy), 11);
        chk("t3_drop_pre", 32'(drop_cnt), 0);
      end
      if (e == 5) begin
        chk("t3_occ", 32'(occupancy), 15);
        chk("t3_drop", 32'(drop_cnt), 3);
        chk("t3_ovf", 32'(overflow), 1);
      end
    end
    cluster_valid = 1'b0;
    chk("t3_occ_end", 32'(occupancy), 0);

    // Resync with occupancy 9 and a simultaneous strobe
    set_cl(8, 14'h1000); cluster_valid = 1'b1;
    tick();
    set_cl(2, 14'h0201);
    tick();
    chk("t4_occ_pre", 32'(occupancy), 9);
    set_cl(8, 14'h0400); resync = 1'b1;
    tick();
    resync = 1'b0;
    chk("t4_occ", 32'(occupancy), 0);
    chk("t4_tx_data", 32'(tx_data), 32'h7FF);
    chk("t4_tx_valid", 32'(tx_valid), 0);
    chk("t4_fs", 32'(tx_frame_start), 0);
    chk("t4_drop", 32'(drop_cnt), 3);
    chk("t4_ovf", 32'(overflow), 1);
    set_cl(1, 14'h0123);
    tick();
    cluster_valid = 1'b0;
    chk("t4_occ1", 32'(occupancy), 1);
    chk("t4_lat_idle", 32'(tx_valid), 0);
    chk("t4_fs_phase0", 32'(tx_frame_start), 1);
    tick();
    chk("t4_data", 32'(tx_data), 32'h0123);
    chk("t4_valid", 32'(tx_valid), 1);
    chk("t4_fs_next", 32'(tx_frame_start), 0);
    tick();
    chk("t4_idle", 32'(tx_valid), 0);

    // Drive drop_cnt to 0xFFFE, then saturate
    occ_m = 0; drop_m = 3; iter = 0;
    cluster_valid = 1'b1;
    while (drop_m < 32'hFFFE && iter < 20000) begin
      f    = int'(DEPTH) - occ_m;
      need = 32'hFFFE - drop_m;
      n    = (need + f > 8) ? 8 : need + f;
      set_cl(n, 14'h0800);
      tick();
      w      = (n < f) ? n : f;
      drop_m = drop_m + n - w;
      occ_m  = occ_m + w - ((occ_m > 0) ? 1 : 0);
      iter++;
    end
    chk("t5_drop_fffe", 32'(drop_cnt), 32'hFFFE);
    chk("t5_occ", 32'(occupancy), 32'(occ_m));
    chk("t5_valid", 32'(tx_valid), 1);
    set_cl(8, 14'h0800);
    tick();
    chk("t5_drop_sat", 32'(drop_cnt), 32'hFFFF);
    tick();
    chk("t5_drop_hold", 32'(drop_cnt), 32'hFFFF);
    chk("t5_ovf", 32'(overflow), 1);
    cluster_valid = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
